// File: rtl/systolic_pkg.sv
// Shared state encoding and sizing helpers for the systolic array front end.
package systolic_pkg;

  typedef enum logic [2:0] {
    LOAD   = 3'b001,
    STREAM = 3'b010,
    DONE   = 3'b100
  } feeder_state_e;

  function automatic int feeder_steps(input int k, input int h, input int w);
    return k + ((h > w) ? h : w) - 1;
  endfunction

  function automatic int feeder_words(input int k, input int h, input int w);
    return feeder_steps(k, h, w) * (h + w);
  endfunction

  function automatic int feeder_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feeder_store.sv
// Flop storage for A (H x K, row-major) and B (K x W, row-major) behind one linear write port.
// Reads are combinational and see a word written in the same cycle.
module feeder_store
  import systolic_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int depth_p        = 2,
  localparam int a_words_lp = array_height_p * depth_p,
  localparam int b_words_lp = depth_p * array_width_p,
  localparam int idx_w_lp   = feeder_cw(a_words_lp + b_words_lp),
  localparam int row_w_lp   = feeder_cw(array_height_p),
  localparam int col_w_lp   = feeder_cw(array_width_p),
  localparam int dep_w_lp   = feeder_cw(depth_p)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [idx_w_lp-1:0] widx_i,
  input  logic [width_p-1:0]  wdata_i,
  input  logic [row_w_lp-1:0] a_row_i,
  input  logic [dep_w_lp-1:0] a_col_i,
  output logic [width_p-1:0]  a_data_o,
  input  logic [dep_w_lp-1:0] b_row_i,
  input  logic [col_w_lp-1:0] b_col_i,
  output logic [width_p-1:0]  b_data_o
);

  localparam int a_aw_lp = feeder_cw(a_words_lp);
  localparam int b_aw_lp = feeder_cw(b_words_lp);

  logic [width_p-1:0] a_mem_q [a_words_lp];
  logic [width_p-1:0] b_mem_q [b_words_lp];

  int   w_lin_s;
  int   b_wlin_s;
  int   a_lin_s;
  int   b_lin_s;
  logic a_sel_s;

  // Linear write and read addresses
  always_comb begin
    w_lin_s  = int'(widx_i);
    a_sel_s  = (w_lin_s < a_words_lp);
    b_wlin_s = w_lin_s - a_words_lp;
    a_lin_s  = int'(a_row_i) * depth_p + int'(a_col_i);
    b_lin_s  = int'(b_row_i) * array_width_p + int'(b_col_i);
  end

  // Operand write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (a_sel_s) begin
        a_mem_q[a_lin_w(w_lin_s)] <= wdata_i;
      end else begin
        b_mem_q[b_lin_w(b_wlin_s)] <= wdata_i;
      end
    end
  end

  // Read ports with same-cycle write forwarding
  always_comb begin
    if (we_i && a_sel_s && (w_lin_s == a_lin_s)) begin
      a_data_o = wdata_i;
    end else begin
      a_data_o = a_mem_q[a_lin_w(a_lin_s)];
    end
    if (we_i && !a_sel_s && (b_wlin_s == b_lin_s)) begin
      b_data_o = wdata_i;
    end else begin
      b_data_o = b_mem_q[b_lin_w(b_lin_s)];
    end
  end

  function automatic logic [a_aw_lp-1:0] a_lin_w(input int lin);
    return a_aw_lp'(lin);
  endfunction

  function automatic logic [b_aw_lp-1:0] b_lin_w(input int lin);
    return b_aw_lp'(lin);
  endfunction

endmodule

// File: rtl/matrix_feeder.sv
// Operand feeder: buffers A and B, then replays them as one skewed, zero-padded word stream.
// Build option MATRIX_FEEDER_B_KEEP_EN adds keep_b_i so a run can reuse the stored B.
module matrix_feeder
  import systolic_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int depth_p        = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
`ifdef MATRIX_FEEDER_B_KEEP_EN
  input  logic               keep_b_i,
`endif
  input  logic               ld_valid_i,
  output logic               ld_ready_o,
  input  logic [width_p-1:0] ld_data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] data_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int a_words_lp  = array_height_p * depth_p;
  localparam int ld_words_lp = a_words_lp + depth_p * array_width_p;
  localparam int lanes_lp    = array_width_p + array_height_p;
  localparam int steps_lp    = feeder_steps(depth_p, array_height_p, array_width_p);
  localparam int idx_w_lp    = feeder_cw(ld_words_lp);
  localparam int step_w_lp   = feeder_cw(steps_lp);
  localparam int lane_w_lp   = feeder_cw(lanes_lp);
  localparam int row_w_lp    = feeder_cw(array_height_p);
  localparam int col_w_lp    = feeder_cw(array_width_p);
  localparam int dep_w_lp    = feeder_cw(depth_p);
  localparam int skew_w_lp   = feeder_cw(steps_lp + lanes_lp) + 1;

  localparam logic [idx_w_lp-1:0]         last_ld_lp    = idx_w_lp'(ld_words_lp - 1);
  localparam logic [step_w_lp-1:0]        last_step_lp  = step_w_lp'(steps_lp - 1);
  localparam logic [lane_w_lp-1:0]        last_lane_lp  = lane_w_lp'(lanes_lp - 1);
  localparam logic [lane_w_lp-1:0]        col_lanes_lp  = lane_w_lp'(array_width_p);
  localparam logic signed [skew_w_lp-1:0] skew_zero_lp  = skew_w_lp'(0);
  localparam logic signed [skew_w_lp-1:0] skew_depth_lp = skew_w_lp'(depth_p);
`ifdef MATRIX_FEEDER_B_KEEP_EN
  localparam logic [idx_w_lp-1:0]         last_ld_a_lp  = idx_w_lp'(a_words_lp - 1);
`endif

  feeder_state_e          state_q;
  logic [idx_w_lp-1:0]    ld_cnt_q;
  logic [step_w_lp-1:0]   step_q;
  logic [lane_w_lp-1:0]   lane_q;
  logic                   ld_ready_q;
  logic                   valid_q;
  logic [width_p-1:0]     data_q;
  logic                   busy_q;
  logic                   done_q;
`ifdef MATRIX_FEEDER_B_KEEP_EN
  logic                   keep_b_q;
`endif

  logic                   ld_xfer_s;
  logic                   out_xfer_s;
  logic                   ld_last_s;
  logic                   out_last_s;
  logic [idx_w_lp-1:0]    ld_cnt_d;
  logic [step_w_lp-1:0]   step_d;
  logic [lane_w_lp-1:0]   lane_d;
  logic [step_w_lp-1:0]   pos_step_s;
  logic [lane_w_lp-1:0]   pos_lane_s;
  logic [lane_w_lp-1:0]   sub_lane_s;
  logic                   is_col_s;
  logic signed [skew_w_lp-1:0] skew_s;
  logic                   in_range_s;
  logic [width_p-1:0]     a_rd_s;
  logic [width_p-1:0]     b_rd_s;
  logic [width_p-1:0]     word_s;

  // Handshakes, counter successors and the position of the next word to present
  always_comb begin
    ld_xfer_s  = ld_valid_i & ld_ready_q & en_i;
    out_xfer_s = valid_q & ready_i & en_i;
    ld_cnt_d   = ld_cnt_q + idx_w_lp'(1);
    out_last_s = (step_q == last_step_lp) && (lane_q == last_lane_lp);
`ifdef MATRIX_FEEDER_B_KEEP_EN
    if (keep_b_q) begin
      ld_last_s = (ld_cnt_q == last_ld_a_lp);
    end else begin
      ld_last_s = (ld_cnt_q == last_ld_lp);
    end
`else
    ld_last_s = (ld_cnt_q == last_ld_lp);
`endif
    if (lane_q == last_lane_lp) begin
      lane_d = lane_w_lp'(0);
      step_d = step_q + step_w_lp'(1);
    end else begin
      lane_d = lane_q + lane_w_lp'(1);
      step_d = step_q;
    end
    // In LOAD the word being prepared is the very first one of the run.
    if (state_q == STREAM) begin
      pos_step_s = step_d;
      pos_lane_s = lane_d;
    end else begin
      pos_step_s = step_w_lp'(0);
      pos_lane_s = lane_w_lp'(0);
    end
  end

  // Skew window and zero padding for the word at the prepared position
  always_comb begin
    is_col_s = (pos_lane_s < col_lanes_lp);
    if (is_col_s) begin
      sub_lane_s = pos_lane_s;
    end else begin
      sub_lane_s = pos_lane_s - col_lanes_lp;
    end
    skew_s     = $signed(skew_w_lp'(pos_step_s)) - $signed(skew_w_lp'(sub_lane_s));
    in_range_s = (skew_s >= skew_zero_lp) && (skew_s < skew_depth_lp);
    if (!in_range_s) begin
      word_s = {width_p{1'b0}};
    end else if (is_col_s) begin
      word_s = b_rd_s;
    end else begin
      word_s = a_rd_s;
    end
  end

  feeder_store #(
    .width_p       (width_p),
    .array_width_p (array_width_p),
    .array_height_p(array_height_p),
    .depth_p       (depth_p)
  ) u_store (
    .clk_i   (clk_i),
    .we_i    (ld_xfer_s),
    .widx_i  (ld_cnt_q),
    .wdata_i (ld_data_i),
    .a_row_i (sub_lane_s[row_w_lp-1:0]),
    .a_col_i (skew_s[dep_w_lp-1:0]),
    .a_data_o(a_rd_s),
    .b_row_i (skew_s[dep_w_lp-1:0]),
    .b_col_i (sub_lane_s[col_w_lp-1:0]),
    .b_data_o(b_rd_s)
  );

  // Control FSM with registered handshake, data and status outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= LOAD;
      ld_cnt_q   <= idx_w_lp'(0);
      step_q     <= step_w_lp'(0);
      lane_q     <= lane_w_lp'(0);
      ld_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      data_q     <= {width_p{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MATRIX_FEEDER_B_KEEP_EN
      keep_b_q   <= keep_b_i;
`endif
    end else if (en_i) begin
      case (state_q)
        LOAD: begin
          if (ld_xfer_s) begin
            if (ld_last_s) begin
              state_q    <= STREAM;
              ld_cnt_q   <= idx_w_lp'(0);
              ld_ready_q <= 1'b0;
              valid_q    <= 1'b1;
              busy_q     <= 1'b1;
              data_q     <= word_s;
            end else begin
              ld_cnt_q <= ld_cnt_d;
            end
          end
        end
        STREAM: begin
          if (out_xfer_s) begin
            if (out_last_s) begin
              state_q <= DONE;
              step_q  <= step_w_lp'(0);
              lane_q  <= lane_w_lp'(0);
              valid_q <= 1'b0;
              data_q  <= {width_p{1'b0}};
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              step_q <= step_d;
              lane_q <= lane_d;
              data_q <= word_s;
            end
          end
        end
        DONE: begin
          state_q    <= LOAD;
          done_q     <= 1'b0;
          ld_ready_q <= 1'b1;
`ifdef MATRIX_FEEDER_B_KEEP_EN
          keep_b_q   <= keep_b_i;
`endif
        end
        default: begin
          state_q    <= LOAD;
          ld_cnt_q   <= idx_w_lp'(0);
          step_q     <= step_w_lp'(0);
          lane_q     <= lane_w_lp'(0);
          ld_ready_q <= 1'b1;
          valid_q    <= 1'b0;
          data_q     <= {width_p{1'b0}};
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready_o = ld_ready_q;
  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_matrix_feeder.sv
// Scoreboard bench for matrix_feeder: directed runs push expected words, a monitor pops and compares.
module tb_matrix_feeder;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        en_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [31:0] ld_data_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic        busy_o;
  logic        done_o;
`ifdef MATRIX_FEEDER_B_KEEP_EN
  logic        keep_b_i;
`endif

  always #5 clk_i = ~clk_i;

  matrix_feeder dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (en_i),
`ifdef MATRIX_FEEDER_B_KEEP_EN
    .keep_b_i  (keep_b_i),
`endif
    .ld_valid_i(ld_valid_i),
    .ld_ready_o(ld_ready_o),
    .ld_data_i (ld_data_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  // Load words: A row-major then B row-major; expected streams worked out by hand.
  logic [31:0] ld_a  [8]  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
  logic [31:0] ld_r  [8]  = '{32'd2, 32'd0, 32'd0, 32'd2, 32'd5, 32'd6, 32'd7, 32'd8};
  logic [31:0] exp_a [12] = '{32'd5, 32'd0, 32'd1, 32'd0, 32'd7, 32'd6, 32'd2, 32'd3,
                              32'd0, 32'd8, 32'd0, 32'd4};
  logic [31:0] exp_r [12] = '{32'd5, 32'd0, 32'd2, 32'd0, 32'd7, 32'd6, 32'd0, 32'd0,
                              32'd0, 32'd8, 32'd0, 32'd2};
`ifdef MATRIX_FEEDER_B_KEEP_EN
  logic [31:0] ld_k  [8]  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
  logic [31:0] exp_k [12] = '{32'd5, 32'd0, 32'd1, 32'd0, 32'd7, 32'd6, 32'd1, 32'd1,
                              32'd0, 32'd8, 32'd0, 32'd1};
`endif

  exp_t        exp_q [$];
  exp_t        mon_e;
  int          n_tests    = 0;
  int          n_fail     = 0;
  int          runs_done  = 0;
  int          popped_run = 0;
  bit          pend_done  = 1'b0;
  bit          hold_prev  = 1'b0;
  logic [31:0] hold_data  = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: actual=event required=no event", name);
  endtask

  // Monitor: pops the scoreboard on every output transfer, checks stalls and the done pulse.
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        pend_done = 1'b0;
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("stall_valid", 32'(valid_o), 32'd1);
          check("stall_data", data_o, hold_data);
        end
        if (pend_done) begin
          check("done_pulse", 32'(done_o), 32'd1);
          runs_done++;
          pend_done = 1'b0;
        end else begin
          check("done_idle", 32'(done_o), 32'd0);
        end
        if (valid_o && ready_i && en_i) begin
          if (exp_q.size() == 0) begin
            fail_now("extra_word");
          end else begin
            mon_e = exp_q.pop_front();
            check("word", data_o, mon_e.data);
            popped_run++;
            if (mon_e.last) pend_done = 1'b1;
          end
        end
        hold_prev = valid_o && !(ready_i && en_i);
        hold_data = data_o;
      end
    end
  end

  task automatic start_run(input logic [31:0] e [12]);
    popped_run = 0;
    for (int i = 0; i < 12; i++) exp_q.push_back({(i == 11), e[i]});
  endtask

  task automatic load_words(input logic [31:0] w [8], input int n);
    int wait_cnt;
    for (int i = 0; i < n; i++) begin
      ld_valid_i = 1'b1;
      ld_data_i  = w[i];
      wait_cnt   = 0;
      @(negedge clk_i);
      while (!ld_ready_o && wait_cnt < 50) begin
        @(negedge clk_i);
        wait_cnt++;
      end
      if (!ld_ready_o) fail_now("load_timeout");
      @(posedge clk_i);
      #1;
    end
    ld_valid_i = 1'b0;
    check("first_valid", 32'(valid_o), 32'd1);
    check("ld_ready_drop", 32'(ld_ready_o), 32'd0);
    check("busy_stream", 32'(busy_o), 32'd1);
  endtask

  task automatic run_wait(input bit toggle, input int freeze_at, input bit garbage, input int abort_at);
    int target;
    int cyc;
    bit frozen;
    target = runs_done + 1;
    cyc    = 0;
    frozen = 1'b0;
    while (runs_done < target && cyc < 400) begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (garbage) begin
        ld_valid_i = 1'b1;
        ld_data_i  = 32'hDEAD_BEEF;
      end
      if (toggle) ready_i = ~ready_i;
      if (abort_at >= 0 && popped_run == abort_at) begin
        reset_i = 1'b1;
        exp_q.delete();
        @(posedge clk_i);
        #1;
        check("abort_valid", 32'(valid_o), 32'd0);
        check("abort_ld_ready", 32'(ld_ready_o), 32'd1);
        check("abort_busy", 32'(busy_o), 32'd0);
        reset_i = 1'b0;
        return;
      end
      if (!frozen && freeze_at >= 0 && popped_run == freeze_at) begin
        frozen = 1'b1;
        en_i   = 1'b0;
        repeat (3) begin
          @(posedge clk_i);
          #1;
          check("freeze_busy", 32'(busy_o), 32'd1);
          check("freeze_ld_ready", 32'(ld_ready_o), 32'd0);
        end
        en_i = 1'b1;
      end
    end
    ld_valid_i = 1'b0;
    if (runs_done < target) fail_now("run_timeout");
  endtask

  initial begin
    reset_i    = 1'b1;
    en_i       = 1'b1;
    ld_valid_i = 1'b0;
    ld_data_i  = 32'd0;
    ready_i    = 1'b1;
`ifdef MATRIX_FEEDER_B_KEEP_EN
    keep_b_i   = 1'b0;
`endif
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ld_ready", 32'(ld_ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    reset_i = 1'b0;

    start_run(exp_a);
    load_words(ld_a, 8);
    run_wait(1'b0, -1, 1'b0, -1);

    start_run(exp_a);
    load_words(ld_a, 8);
    run_wait(1'b1, -1, 1'b0, -1);
    ready_i = 1'b1;

    start_run(exp_a);
    load_words(ld_a, 8);
    run_wait(1'b0, 4, 1'b1, -1);

    start_run(exp_a);
    load_words(ld_a, 8);
    run_wait(1'b0, -1, 1'b0, 5);
    check("abort_flushed", 32'(exp_q.size()), 32'd0);

    start_run(exp_r);
    load_words(ld_r, 8);
    run_wait(1'b0, -1, 1'b0, -1);

`ifdef MATRIX_FEEDER_B_KEEP_EN
    keep_b_i = 1'b1;
    reset_i  = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i  = 1'b0;
    keep_b_i = 1'b0;
    start_run(exp_k);
    load_words(ld_k, 4);
    run_wait(1'b0, -1, 1'b0, -1);
`endif

    repeat (3) @(posedge clk_i);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("idle_ld_ready", 32'(ld_ready_o), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
